// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: shared mips_para constants (aluop encodings, opcode/funct values, entry layout).
// ALU_ISSUE_ILLEGAL_EN adds an illegal flag to each buffered entry.
package alu_issue_stage_pkg;

    typedef enum logic [3:0] {
        alu_shl  = 4'd0,
        alu_shr  = 4'd1,
        alu_sar  = 4'd2,
        alu_add  = 4'd3,
        alu_sub  = 4'd4,
        alu_and  = 4'd5,
        alu_or   = 4'd6,
        alu_xor  = 4'd7,
        alu_nor  = 4'd8,
        alu_slt  = 4'd9,
        alu_sltu = 4'd10
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam int ENTRY_W = 32 + 32 + 4 + 1;
`else
    localparam int ENTRY_W = 32 + 32 + 4;
`endif

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        aluop_e      aluop;
`ifdef ALU_ISSUE_ILLEGAL_EN
        logic        illegal;
`endif
    } entry_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_issue_decode: combinational MIPS instruction + rs/rt -> srca, srcb, aluop.
// Illegal encodings collapse to add of zeros; ALU_ISSUE_ILLEGAL_EN also exports the illegal flag.
module alu_issue_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic [31:0] srca_o,
    output logic [31:0] srcb_o,
    output aluop_e      aluop_o
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic        illegal_o
`endif
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] shamt;
    logic [31:0] sx;
    logic [31:0] zx;
    logic [31:0] a;
    logic [31:0] b;
    aluop_e      alu;
    logic        legal;

    assign op    = instr_i[31:26];
    assign fn    = instr_i[5:0];
    assign shamt = {27'd0, instr_i[10:6]};
    assign sx    = {{16{instr_i[15]}}, instr_i[15:0]};
    assign zx    = {16'd0, instr_i[15:0]};

    always_comb begin
        a     = rs_data_i;
        b     = rt_data_i;
        alu   = alu_add;
        legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL:  begin a = rt_data_i; b = shamt;     alu = alu_shl; end
                    FN_SRL:  begin a = rt_data_i; b = shamt;     alu = alu_shr; end
                    FN_SRA:  begin a = rt_data_i; b = shamt;     alu = alu_sar; end
                    FN_SLLV: begin a = rt_data_i; b = rs_data_i; alu = alu_shl; end
                    FN_SRLV: begin a = rt_data_i; b = rs_data_i; alu = alu_shr; end
                    FN_SRAV: begin a = rt_data_i; b = rs_data_i; alu = alu_sar; end
                    FN_ADD, FN_ADDU: alu = alu_add;
                    FN_SUB, FN_SUBU: alu = alu_sub;
                    FN_AND:  alu = alu_and;
                    FN_OR:   alu = alu_or;
                    FN_XOR:  alu = alu_xor;
                    FN_NOR:  alu = alu_nor;
                    FN_SLT:  alu = alu_slt;
                    FN_SLTU: alu = alu_sltu;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: b = sx;
            OP_SLTI:  begin b = sx; alu = alu_slt;  end
            OP_SLTIU: begin b = sx; alu = alu_sltu; end
            OP_ANDI:  begin b = zx; alu = alu_and;  end
            OP_ORI:   begin b = zx; alu = alu_or;   end
            OP_XORI:  begin b = zx; alu = alu_xor;  end
            OP_LUI:   begin a = zx; b = 32'd16; alu = alu_shl; end
            OP_BEQ, OP_BNE: alu = alu_sub;
            default:  legal = 1'b0;
        endcase
    end

    // Masking at the output keeps every decode branch free of illegal handling.
    assign srca_o  = legal ? a : 32'd0;
    assign srcb_o  = legal ? b : 32'd0;
    assign aluop_o = legal ? alu : alu_add;

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign illegal_o = !legal;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX operand issue stage with a 2-entry (main + skid) FIFO and flush.
// ALU_ISSUE_ILLEGAL_EN adds illegal_o and the sticky illegal_seen_o outputs.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   instr_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic          flush_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] srca_o,
    output logic [DW-1:0] srcb_o,
    output logic [3:0]    aluop_o
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic          illegal_o,
    output logic          illegal_seen_o
`endif
);

    entry_t              dec;
    entry_t              head;
    logic [ENTRY_W-1:0]  dec_w;
    logic [ENTRY_W-1:0]  main_q, main_d;
    logic [ENTRY_W-1:0]  skid_q, skid_d;
    logic                main_v_q, main_v_d;
    logic                skid_v_q, skid_v_d;
    logic                in_ready_q;
    logic                push;
    logic                pop;

    alu_issue_decode u_decode (
        .instr_i   (instr_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .srca_o    (dec.srca),
        .srcb_o    (dec.srcb),
        .aluop_o   (dec.aluop)
`ifdef ALU_ISSUE_ILLEGAL_EN
        ,
        .illegal_o (dec.illegal)
`endif
    );

    assign dec_w = dec;
    assign push  = in_valid_i && in_ready_q;
    assign pop   = main_v_q && out_ready_i;

    // in_ready is held low only while skid is full, so no push can arrive then.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (pop) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (push) begin
            if (!main_v_q || pop) begin
                main_d   = dec_w;
                main_v_d = 1'b1;
            end else begin
                skid_d   = dec_w;
                skid_v_d = 1'b1;
            end
        end else if (pop) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= !skid_v_d;
        end
    end

    assign head        = main_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_v_q;
    assign srca_o      = head.srca;
    assign srcb_o      = head.srcb;
    assign aluop_o     = head.aluop;

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else if (push && dec.illegal) begin
            seen_q <= 1'b1;
        end
    end

    assign illegal_o      = head.illegal;
    assign illegal_seen_o = seen_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage; randomized plus directed stimulus.
// Build with ALU_ISSUE_ILLEGAL_EN to also cover illegal_o / illegal_seen_o.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    localparam logic [5:0] R_FN [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                         6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    localparam logic [5:0] I_OP [12] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                                         6'h0e, 6'h0f, 6'h23, 6'h2b};
    localparam logic [3:0] ARITH [12] = '{alu_add, alu_add, alu_sub, alu_sub, alu_and, alu_or,
                                          alu_xor, alu_nor, alu_add, alu_add, alu_slt, alu_sltu};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready_o;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        out_valid_o;
    logic        out_ready = 1'b0;
    logic [31:0] srca_o;
    logic [31:0] srcb_o;
    logic [3:0]  aluop_o;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        illegal_o;
    logic        illegal_seen_o;
`endif

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic seen_m = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_a, prev_b;
    logic [3:0]  prev_op;

    alu_issue_stage #(.DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr),
        .rs_data_i   (rs_data),
        .rt_data_i   (rt_data),
        .flush_i     (flush),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .srca_o      (srca_o),
        .srcb_o      (srcb_o),
        .aluop_o     (aluop_o)
`ifdef ALU_ISSUE_ILLEGAL_EN
        ,
        .illegal_o      (illegal_o),
        .illegal_seen_o (illegal_seen_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t m;
        m.a = a; m.b = b; m.op = op; m.ill = 1'b0;
        return m;
    endfunction

    // Reference decode written from the instruction-set rules, not the RTL structure.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t m;
        logic [5:0] op, f;
        logic [31:0] sx, zx;
        op = ins[31:26];
        f  = ins[5:0];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'd0, ins[15:0]};
        m.a = 0; m.b = 0; m.op = alu_add; m.ill = 1'b1;
        if (op == 6'h00 && f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07})
            m = mk(rt, f[2] ? rs : 32'(ins[10:6]),
                   f[1:0] == 2'd0 ? alu_shl : f[1:0] == 2'd2 ? alu_shr : alu_sar);
        else if (op == 6'h00 && f inside {[6'h20:6'h27], 6'h2a, 6'h2b})
            m = mk(rs, rt, ARITH[f[3:0]]);
        else if (op inside {6'h08, 6'h09, 6'h23, 6'h2b}) m = mk(rs, sx, alu_add);
        else if (op == 6'h0a) m = mk(rs, sx, alu_slt);
        else if (op == 6'h0b) m = mk(rs, sx, alu_sltu);
        else if (op == 6'h0c) m = mk(rs, zx, alu_and);
        else if (op == 6'h0d) m = mk(rs, zx, alu_or);
        else if (op == 6'h0e) m = mk(rs, zx, alu_xor);
        else if (op == 6'h0f) m = mk(zx, 32'd16, alu_shl);
        else if (op inside {6'h04, 6'h05}) m = mk(rs, rt, alu_sub);
        return m;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4) begin
            w[31:26] = 6'h00;
            w[5:0] = R_FN[$urandom_range(0, 15)];
        end else if (k < 8) begin
            w[31:26] = I_OP[$urandom_range(0, 11)];
        end
        return w;
    endfunction

    // Monitor: queue occupancy mirrors the buffer; pops are compared against the model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            seen_m = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready_o), 32'(q.size() < 2));
            check("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
`ifdef ALU_ISSUE_ILLEGAL_EN
            check("illegal_seen", 32'(illegal_seen_o), 32'(seen_m));
`endif
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_srca", srca_o, prev_a);
                check("hold_srcb", srcb_o, prev_b);
                check("hold_aluop", 32'(aluop_o), 32'(prev_op));
            end
            if (out_valid_o && out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("srca", srca_o, e.a);
                check("srcb", srcb_o, e.b);
                check("aluop", 32'(aluop_o), 32'(e.op));
`ifdef ALU_ISSUE_ILLEGAL_EN
                check("illegal", 32'(illegal_o), 32'(e.ill));
`endif
            end
            if (in_valid && in_ready_o) begin
                e = model(instr, rs_data, rt_data);
                if (e.ill) seen_m = 1'b1;
                if (!flush) q.push_back(e);
            end
            if (flush) q.delete();
            prev_stall = out_valid_o && !out_ready && !flush;
            prev_a = srca_o;
            prev_b = srcb_o;
            prev_op = aluop_o;
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic wait_accept(output int n);
        logic acc;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins);
        int n;
        in_valid = 1'b1;
        instr = ins;
        rs_data = $urandom;
        rt_data = $urandom;
        wait_accept(n);
    endtask

    task automatic directed(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [3:0] eop, input logic eill);
        in_valid = 1'b1; instr = ins; rs_data = rs; rt_data = rt; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid_o), 32'd1);
        check({nm, "_ready"}, 32'(in_ready_o), 32'd1);
        check({nm, "_srca"}, srca_o, ea);
        check({nm, "_srcb"}, srcb_o, eb);
        check({nm, "_aluop"}, 32'(aluop_o), 32'(eop));
`ifdef ALU_ISSUE_ILLEGAL_EN
        check({nm, "_illegal"}, 32'(illegal_o), 32'(eill));
`else
        if (eill) check({nm, "_as_add"}, 32'(aluop_o), 32'(alu_add));
`endif
        @(posedge clk); #1;
    endtask

    task automatic flush_after_fill(input string nm, input int fill);
        out_ready = 1'b0;
        for (int i = 0; i < fill; i++) send(rand_instr());
        in_valid = 1'b1; instr = 32'h00221820; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid_o), 32'd0);
        check({nm, "_ready"}, 32'(in_ready_o), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check({nm, "_quiet"}, 32'(out_valid_o), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] ia, ib, ic;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_srca", srca_o, 32'd0);
        check("rst_srcb", srcb_o, 32'd0);
        check("rst_aluop", 32'(aluop_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("add", 32'h00221820, 32'd5, 32'd7, 32'd5, 32'd7, alu_add, 1'b0);
        directed("sra", 32'h00031883, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'd2, alu_sar, 1'b0);
        directed("andi", 32'h3022FFFF, 32'hA5A5_0000, 32'd0, 32'hA5A5_0000, 32'h0000_FFFF, alu_and, 1'b0);
        directed("addi", 32'h2022FFFF, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, alu_add, 1'b0);
        directed("lui", 32'h3C011234, 32'hDEAD_BEEF, 32'd3, 32'h0000_1234, 32'd16, alu_shl, 1'b0);
        directed("sllv", 32'h00221804, 32'd33, 32'hF0, 32'hF0, 32'd33, alu_shl, 1'b0);
        directed("bne", 32'h14220004, 32'd11, 32'd12, 32'd11, 32'd12, alu_sub, 1'b0);
        directed("illegal", 32'hFC00_0000, 32'd4, 32'd5, 32'd0, 32'd0, alu_add, 1'b1);
        @(posedge clk); #1;

        // Backpressure: two accepted, third stalls until the buffer drains.
        out_ready = 1'b0;
        ia = rand_instr(); ib = rand_instr(); ic = rand_instr();
        send(ia);
        send(ib);
        in_valid = 1'b1; instr = ic;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", 32'(in_ready_o), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(n);
        check("bp_accept_cycles", 32'(n), 32'd2);
        repeat (3) @(posedge clk);
        #1;

        flush_after_fill("flush_full", 2);
        flush_after_fill("flush_one", 1);

        for (int c = 0; c < 3000; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            instr = rand_instr();
            rs_data = $urandom;
            rt_data = $urandom;
            out_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 40) == 0;
            if (flush) out_ready = 1'b0;
            if (c == 1500) begin
                in_valid = 1'b1; instr = 32'hFC00_0000; flush = 1'b0;
            end
            @(posedge clk); #1;
            if (c == 1510) begin
                flush = 1'b0;
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_valid", 32'(out_valid_o), 32'd0);
                check("mid_rst_ready", 32'(in_ready_o), 32'd1);
                check("mid_rst_srca", srca_o, 32'd0);
                check("mid_rst_srcb", srcb_o, 32'd0);
                check("mid_rst_aluop", 32'(aluop_o), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
                check("mid_rst_seen", 32'(illegal_seen_o), 32'd0);
`endif
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/opcode interface: decodes a MIPS instruction plus register-file read data into srca, srcb and aluop for the combinational ALU.
- Registered pipeline stage (ID to EX) with a valid/ready handshake on both sides and a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Supports flush for branch redirect.

Parameters:
- DW, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  stage clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid_i  input  1  upstream instruction valid
- in_ready_o  output  1  stage can accept an instruction
- instr_i  input  32  instruction word
- rs_data_i  input  32  register value of rs
- rt_data_i  input  32  register value of rt
- flush_i  input  1  discard all buffered entries this cycle
- out_valid_o  output  1  srca/srcb/aluop valid toward the ALU
- out_ready_i  input  1  EX consumes the entry
- srca_o  output  32  ALU operand 1
- srcb_o  output  32  ALU operand 2
- aluop_o  output  4  ALU operation code; encodings come from the shared mips_para header (alu_shl … alu_sltu)

Behaviour:
- Reset (async, rst_n=0): both buffer entries invalid; out_valid_o=0; in_ready_o=1; srca_o, srcb_o and aluop_o are 0.
- Transfers:
  - Input transfer occurs when in_valid_i&&in_ready_o.
  - Output transfer occurs when out_valid_o&&out_ready_i.
- Latency: an accepted instruction appears at the outputs the next cycle if the buffer was empty.
- Ordering: the buffer is strict FIFO with 2 entries, main and skid.
  - in_ready_o is a register: 1 whenever the skid entry is empty.
  - Full (2 valid entries): in_ready_o=0 and inputs are ignored.
- Simultaneous push and pop at 1 entry: occupancy stays 1 and the outputs update to the new entry.
- Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- flush_i: next cycle both entries are invalid; any same-cycle input transfer is dropped. flush_i has priority over push and pop.
- Decode, R-type (op=0x00), keyed on funct:
  - sll/srl/sra (0x00/02/03): srca=rt, srcb=zero-extended shamt; aluop shl/shr/sar.
  - sllv/srlv/srav (0x04/06/07): srca=rt, srcb=rs; aluop shl/shr/sar.
  - add/addu → add; sub/subu → sub; and, or, xor, nor, slt, sltu map to their like-named aluop. For all of these, srca=rs, srcb=rt.
- Decode, I-type:
  - addi/addiu/lw/sw (0x08/09/23/2b): srca=rs, srcb=sign-extended imm16; aluop add.
  - slti/sltiu: sign-extended imm; aluop slt/sltu.
  - andi/ori/xori: zero-extended imm; aluop and/or/xor.
  - lui (0x0f): srca=zero-extended imm, srcb=16; aluop shl.
  - beq/bne (0x04/05): srca=rs, srcb=rt; aluop sub.
- Any other encoding is illegal: srca=0, srcb=0, aluop add.
- Width rules: shift amounts carried in srcb[4:0]; upper srcb bits are 0 for shamt.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_EN.
- With macro:
  - Extra output illegal_o (1 bit) travels with each entry and is 1 for illegal encodings.
  - Extra output illegal_seen_o is sticky, set on acceptance of an illegal instruction, and cleared only by reset.
- Without macro: neither port exists and illegal instructions silently issue as add of zeros.

Decomposition:
- mips_para header holds the aluop encodings, opcode/funct constants and the entry struct width (32+32+4, plus 1 when the feature is enabled).
- One sub-module, alu_issue_decode: purely combinational instruction/rs/rt → {srca, srcb, aluop, illegal}.
- alu_issue_stage holds only the skid-buffer control and storage.

Test Plan:
- Reset then add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready_i=1 → next cycle out_valid_o=1, srca=5, srcb=7, aluop=alu_add; in_ready_o stays 1.
- sra (0x00031883, shamt=2), rt=0x80000000 → srca=0x80000000, srcb=2, aluop=alu_sar; andi imm 0xFFFF → srcb=0x0000FFFF; addi imm 0xFFFF → srcb=0xFFFFFFFF.
- lui 0x3C011234 → srca=0x00001234, srcb=16, aluop=alu_shl.
- Backpressure:
  - Stimulus: out_ready_i=0 while 3 instructions are offered back-to-back.
  - Response: first two are accepted; in_ready_o=0 from the cycle after the second acceptance; outputs are held stable.
  - Release: out_ready_i=1 drains both entries in order, then the third is accepted.
- Flush with 2 entries valid and a same-cycle input transfer → next cycle out_valid_o=0, in_ready_o=1, and nothing is issued afterward.
- With ALU_ISSUE_ILLEGAL_EN, op 0x3F → illegal_o=1, aluop=alu_add, srca=srcb=0; illegal_seen_o=1 until rst_n pulses low mid-stream, which clears everything asynchronously.
